// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Hazard and run-state controller for the five-stage Y86-64
//                pipeline. Produces per-stage stall/bubble controls and the
//                condition-code write enable, sequences FLUSH/RUN/DRAIN/
//                HALTED/WDOG, and guards against runaway fetch stalls.
//                Optional performance counters: define PIPE_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 4,
    parameter int STALL_LIMIT  = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [2:0]       ctrl_state,
    output logic             halted,
    output logic             wdog_err,
    output logic [2:0]       final_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] misp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic [2:0] c_ST_FLUSH  = 3'd0;
    localparam logic [2:0] c_ST_RUN    = 3'd1;
    localparam logic [2:0] c_ST_DRAIN  = 3'd2;
    localparam logic [2:0] c_ST_HALTED = 3'd3;
    localparam logic [2:0] c_ST_WDOG   = 3'd4;

    localparam logic [2:0] c_SAOK = 3'd1;
    localparam logic [2:0] c_SHLT = 3'd2;
    localparam logic [2:0] c_SADR = 3'd3;
    localparam logic [2:0] c_SINS = 3'd4;

    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_POPQ   = 4'hB;
    localparam logic [3:0] c_R_NONE   = 4'hF;

    localparam int c_FW = $clog2(FLUSH_CYCLES + 1);
    localparam int c_WW = $clog2(STALL_LIMIT + 1);

    logic [2:0]      r_state;
    logic [2:0]      w_nextState;
    logic [2:0]      w_curState;
    logic [c_FW-1:0] r_flushCnt;
    logic [c_WW-1:0] r_wdogCnt;
    logic [2:0]      r_finalStat;

    logic w_lu, w_ret, w_misp, w_mExc, w_wExc, w_runFStall, w_wdogTrip;

    assign w_lu   = ((E_icode == c_I_MRMOVQ) || (E_icode == c_I_POPQ)) && (E_dstM != c_R_NONE)
                    && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_ret  = (D_icode == c_I_RET) || (E_icode == c_I_RET) || (M_icode == c_I_RET);
    assign w_misp = (E_icode == c_I_JXX) && !e_Cnd;
    assign w_mExc = (m_stat == c_SHLT) || (m_stat == c_SADR) || (m_stat == c_SINS);
    assign w_wExc = (W_stat == c_SHLT) || (W_stat == c_SADR) || (W_stat == c_SINS);

    assign w_runFStall = w_lu || w_ret;
    // Trip on the stalled cycle that would bring the run of stalls to STALL_LIMIT.
    assign w_wdogTrip  = w_runFStall && (r_wdogCnt == c_WW'(STALL_LIMIT - 1));

    // While reset is asserted the controls behave as FLUSH regardless of the stored state.
    assign w_curState = rst_n ? r_state : c_ST_FLUSH;

    // Pipeline controls from the effective state and next-state selection.
    always_comb begin
        F_stall     = 1'b0;
        D_stall     = 1'b0;
        D_bubble    = 1'b0;
        E_bubble    = 1'b0;
        M_bubble    = 1'b0;
        W_stall     = 1'b0;
        set_cc      = 1'b0;
        w_nextState = r_state;
        case (w_curState)
            c_ST_RUN: begin
                F_stall  = w_runFStall;
                D_stall  = w_lu;
                D_bubble = w_misp || (w_ret && !w_lu);
                E_bubble = w_misp || w_lu;
                M_bubble = w_mExc || w_wExc;
                W_stall  = w_wExc;
                set_cc   = (E_icode == c_I_OPQ) && !w_mExc && !w_wExc;
            end
            c_ST_DRAIN: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = w_wExc;
            end
            c_ST_HALTED, c_ST_WDOG: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            default: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
        endcase
        case (r_state)
            c_ST_FLUSH: if (r_flushCnt == c_FW'(FLUSH_CYCLES - 1)) w_nextState = c_ST_RUN;
            c_ST_RUN: begin
                if (w_wExc)          w_nextState = c_ST_HALTED;
                else if (w_mExc)     w_nextState = c_ST_DRAIN;
                else if (w_wdogTrip) w_nextState = c_ST_WDOG;
            end
            c_ST_DRAIN: if (w_wExc) w_nextState = c_ST_HALTED;
            default: w_nextState = r_state;
        endcase
    end

    // State, flush/watchdog counters and the latched processor status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_FLUSH;
            r_flushCnt  <= '0;
            r_wdogCnt   <= '0;
            r_finalStat <= c_SAOK;
        end else begin
            r_state    <= w_nextState;
            r_flushCnt <= (r_state == c_ST_FLUSH) ? r_flushCnt + c_FW'(1) : '0;
            r_wdogCnt  <= ((r_state == c_ST_RUN) && w_runFStall && !w_wdogTrip)
                          ? r_wdogCnt + c_WW'(1) : '0;
            if ((r_state != c_ST_HALTED) && (w_nextState == c_ST_HALTED))
                r_finalStat <= W_stat;
            else if ((r_state != c_ST_WDOG) && (w_nextState == c_ST_WDOG))
                r_finalStat <= c_SINS;
        end
    end

    assign ctrl_state = w_curState;
    assign halted     = (w_curState == c_ST_HALTED) || (w_curState == c_ST_WDOG);
    assign wdog_err   = (w_curState == c_ST_WDOG);
    assign final_stat = rst_n ? r_finalStat : c_SAOK;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycleCnt, r_retiredCnt, r_luCnt, r_mispCnt, r_retCnt;
    logic             w_inRun, w_active;

    assign w_inRun  = (r_state == c_ST_RUN);
    assign w_active = w_inRun || (r_state == c_ST_DRAIN);

    // Saturating event counters; each sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycleCnt   <= '0;
            r_retiredCnt <= '0;
            r_luCnt      <= '0;
            r_mispCnt    <= '0;
            r_retCnt     <= '0;
        end else begin
            if (w_active && (r_cycleCnt != '1))
                r_cycleCnt <= r_cycleCnt + CNT_W'(1);
            if (w_active && (W_stat == c_SAOK) && (r_retiredCnt != '1))
                r_retiredCnt <= r_retiredCnt + CNT_W'(1);
            if (w_inRun && w_lu && (r_luCnt != '1))
                r_luCnt <= r_luCnt + CNT_W'(1);
            if (w_inRun && w_misp && (r_mispCnt != '1))
                r_mispCnt <= r_mispCnt + CNT_W'(1);
            if (w_inRun && w_ret && !w_lu && (r_retCnt != '1))
                r_retCnt <= r_retCnt + CNT_W'(1);
        end
    end

    assign cycle_cnt   = r_cycleCnt;
    assign retired_cnt = r_retiredCnt;
    assign lu_cnt      = r_luCnt;
    assign misp_cnt    = r_mispCnt;
    assign ret_cnt     = r_retCnt;
`else
    assign cycle_cnt   = '0;
    assign retired_cnt = '0;
    assign lu_cnt      = '0;
    assign misp_cnt    = '0;
    assign ret_cnt     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Scoreboard bench for pipe_ctrl: directed vectors push
//                expected outputs, a monitor pops and compares each cycle.
//                Counter expectations follow PIPE_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int c_CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM;
    logic       e_Cnd;
    logic [2:0] m_stat, W_stat;
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic [2:0] ctrl_state, final_stat;
    logic halted, wdog_err;
    logic [c_CW-1:0] cycle_cnt, retired_cnt, lu_cnt, misp_cnt, ret_cnt;

    pipe_ctrl #(.FLUSH_CYCLES(4), .STALL_LIMIT(16), .CNT_W(c_CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
        .ctrl_state(ctrl_state), .halted(halted), .wdog_err(wdog_err),
        .final_stat(final_stat),
        .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .lu_cnt(lu_cnt),
        .misp_cnt(misp_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    // ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    // sts = {halted, wdog_err, final_stat}
    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [6:0] ctl;
        logic [4:0] sts;
        bit         chkCnt;
        logic [19:0] cnt;
    } exp_t;

    localparam logic [6:0] c_FL   = 7'b1011100;
    localparam logic [6:0] c_HALT = 7'b1011110;
    localparam logic [4:0] c_OK   = 5'b00001;

    exp_t q[$];
    int nAssert = 0;
    int nFail   = 0;
    bit chkCnt  = 1'b0;
    logic [19:0] expCnt = '0;

    function automatic logic [3:0] cx(input int v);
`ifdef PIPE_PERF_CNT_EN
        return 4'(v);
`else
        return 4'd0;
`endif
    endfunction

    task automatic setCnt(input int c, input int r, input int l, input int m, input int rt);
        chkCnt = 1'b1;
        expCnt = {cx(c), cx(r), cx(l), cx(m), cx(rt)};
    endtask

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_Cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
    endtask

    // Record this cycle's expectation, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] ctl,
                       input logic [4:0] sts);
        exp_t e;
        e.tag = tag; e.st = st; e.ctl = ctl; e.sts = sts;
        e.chkCnt = chkCnt; e.cnt = expCnt;
        q.push_back(e);
        chkCnt = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest expectation mid-cycle.
    initial begin
        exp_t e;
        logic [6:0]  aCtl;
        logic [4:0]  aSts;
        logic [19:0] aCnt;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e    = q.pop_front();
                aCtl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
                aSts = {halted, wdog_err, final_stat};
                aCnt = {cycle_cnt, retired_cnt, lu_cnt, misp_cnt, ret_cnt};
                nAssert++;
                if (ctrl_state !== e.st) begin
                    nFail++;
                    $display("FAIL %s state: got %0d expected %0d", e.tag, ctrl_state, e.st);
                end
                nAssert++;
                if (aCtl !== e.ctl) begin
                    nFail++;
                    $display("FAIL %s ctl: got %b expected %b", e.tag, aCtl, e.ctl);
                end
                nAssert++;
                if (aSts !== e.sts) begin
                    nFail++;
                    $display("FAIL %s status: got %b expected %b", e.tag, aSts, e.sts);
                end
                if (e.chkCnt) begin
                    nAssert++;
                    if (aCnt !== e.cnt) begin
                        nFail++;
                        $display("FAIL %s counters: got %h expected %h", e.tag, aCnt, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        setCnt(0, 0, 0, 0, 0);
        cyc("rst0", 3'd0, c_FL, c_OK);
        cyc("rst1", 3'd0, c_FL, c_OK);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc("flush", 3'd0, c_FL, c_OK);
        setCnt(0, 0, 0, 0, 0);
        cyc("run0", 3'd1, 7'b0000000, c_OK);

        E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2;
        cyc("loaduse", 3'd1, 7'b1101000, c_OK);
        idle();
        setCnt(2, 2, 1, 0, 0);
        cyc("idle1", 3'd1, 7'b0000000, c_OK);

        E_icode = 4'hB; E_dstM = 4'h3; d_srcA = 4'h3; D_icode = 4'h9;
        cyc("lu_ret", 3'd1, 7'b1101000, c_OK);
        idle();
        E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
        cyc("misp_ret", 3'd1, 7'b1011000, c_OK);
        idle();
        E_icode = 4'h5;
        cyc("lu_none", 3'd1, 7'b0000000, c_OK);
        E_icode = 4'hB; E_dstM = 4'h2; d_srcA = 4'h3; d_srcB = 4'h4;
        cyc("lu_diff", 3'd1, 7'b0000000, c_OK);
        idle();
        E_icode = 4'h6;
        cyc("setcc", 3'd1, 7'b0000001, c_OK);
        m_stat = 3'd2;
        cyc("m_exc", 3'd1, 7'b0000100, c_OK);
        idle();
        setCnt(9, 9, 2, 1, 1);
        cyc("drain0", 3'd2, c_FL, c_OK);
        W_stat = 3'd2;
        cyc("drain_w", 3'd2, c_HALT, c_OK);
        idle();
        setCnt(11, 10, 2, 1, 1);
        cyc("halt0", 3'd3, c_HALT, 5'b10010);
        W_stat = 3'd3; m_stat = 3'd4; E_icode = 4'h6; D_icode = 4'h9;
        setCnt(11, 10, 2, 1, 1);
        cyc("halt_hold", 3'd3, c_HALT, 5'b10010);
        idle();
        cyc("halt_hold2", 3'd3, c_HALT, 5'b10010);

        rst_n = 1'b0;
        cyc("rst_mid", 3'd0, c_FL, c_OK);
        rst_n = 1'b1;
        setCnt(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("flush2", 3'd0, c_FL, c_OK);

        D_icode = 4'h9;
        for (int i = 0; i < 15; i++) cyc("wd_near", 3'd1, 7'b1010000, c_OK);
        idle();
        cyc("wd_clear", 3'd1, 7'b0000000, c_OK);
        D_icode = 4'h9;
        for (int i = 0; i < 16; i++) cyc("wd_run", 3'd1, 7'b1010000, c_OK);
        setCnt(15, 15, 0, 0, 15);
        cyc("wdog", 3'd4, c_HALT, 5'b11100);
        W_stat = 3'd2;
        cyc("wdog_hold", 3'd4, c_HALT, 5'b11100);

        idle();
        rst_n = 1'b0;
        cyc("rst3", 3'd0, c_FL, c_OK);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc("flush3", 3'd0, c_FL, c_OK);
        m_stat = 3'd3; W_stat = 3'd4; E_icode = 4'h6;
        cyc("both_exc", 3'd1, 7'b0000110, c_OK);
        idle();
        cyc("halt_ins", 3'd3, c_HALT, 5'b10100);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            nFail++;
            $display("FAIL drain: %0d expectations left unchecked", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire
